// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides CLOCK_50 by two into a pixel tick and walks
// horizontal/vertical counters that drive sync, blanking and frame markers.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        video_on,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_clk,
    output logic        frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // Inclusive bounds keep every constant representable in the counter width.
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic          pix_tick;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // Counters only move on the second half of each pixel, so a pixel spans two clocks.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pix_tick <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
        end else begin
            pix_tick <= ~pix_tick;
            if (pix_tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST)
                        v_cnt <= '0;
                    else
                        v_cnt <= v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

    assign x         = 12'(h_cnt);
    assign y         = 12'(v_cnt);
    assign vga_clk   = pix_tick;
    assign video_on  = (h_cnt <= H_VIS_LAST) && (v_cnt <= V_VIS_LAST);
    assign vga_hs    = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vga_vs    = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    assign frame_end = pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: default and shrunk geometries checked
// every cycle against an arithmetic model of elapsed clocks since reset release.
module tb_vga_timing_gen;

    localparam int SHA = 8, SHFP = 1, SHS = 2, SHBP = 1;
    localparam int SVA = 4, SVFP = 1, SVS = 1, SVBP = 1;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic [11:0] d_x, d_y, s_x, s_y;
    logic        d_video_on, d_hs, d_vs, d_clk, d_fe;
    logic        s_video_on, s_hs, s_vs, s_clk, s_fe;

    int errorCount = 0;
    int checkCount = 0;
    int n = 0;
    int dHsLow, sVsLow, sFeCount, sLastFe;

    localparam logic [31:0] RESET_VEC = {3'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_timing_gen dut_dflt (
        .CLOCK_50 (CLOCK_50), .resetn (resetn), .x (d_x), .y (d_y),
        .video_on (d_video_on), .vga_hs (d_hs), .vga_vs (d_vs),
        .vga_clk (d_clk), .frame_end (d_fe)
    );

    vga_timing_gen #(
        .H_ACTIVE (SHA), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
        .V_ACTIVE (SVA), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP)
    ) dut_small (
        .CLOCK_50 (CLOCK_50), .resetn (resetn), .x (s_x), .y (s_y),
        .video_on (s_video_on), .vga_hs (s_hs), .vga_vs (s_vs),
        .vga_clk (s_clk), .frame_end (s_fe)
    );

    // Expected outputs after cyc rising edges since release: pixel index is cyc/2.
    function automatic logic [31:0] modelOut(input int cyc, input int ha, input int hfp,
                                             input int hsw, input int hbp, input int va,
                                             input int vfp, input int vsw, input int vbp);
        int   ht, vt, p, mx, my;
        logic von, hs, vs, ck, fe;
        ht  = ha + hfp + hsw + hbp;
        vt  = va + vfp + vsw + vbp;
        p   = cyc / 2;
        mx  = p % ht;
        my  = (p / ht) % vt;
        von = (mx < ha) && (my < va);
        hs  = !((mx >= ha + hfp) && (mx < ha + hfp + hsw));
        vs  = !((my >= va + vfp) && (my < va + vfp + vsw));
        ck  = (cyc % 2) == 1;
        fe  = ck && (mx == ht - 1) && (my == vt - 1);
        return {3'b0, 12'(mx), 12'(my), von, hs, vs, ck, fe};
    endfunction

    function automatic logic [31:0] dVec();
        return {3'b0, d_x, d_y, d_video_on, d_hs, d_vs, d_clk, d_fe};
    endfunction

    function automatic logic [31:0] sVec();
        return {3'b0, s_x, s_y, s_video_on, s_hs, s_vs, s_clk, s_fe};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, n);
        end
    endtask

    task automatic checkBoth();
        checkOutput("dflt", dVec(), modelOut(n, 640, 16, 96, 48, 480, 10, 2, 33));
        checkOutput("small", sVec(), modelOut(n, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP));
    endtask

    // Advance by whole clocks, checking both instances on each falling edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge CLOCK_50);
            n++;
            @(negedge CLOCK_50);
            checkBoth();
            if (!d_hs) dHsLow++;
            if (!s_vs) sVsLow++;
            if (s_fe) begin
                if (sLastFe >= 0)
                    checkOutput("fe_period", 32'(n - sLastFe), 32'd168);
                sLastFe = n;
                sFeCount++;
            end
        end
    endtask

    task automatic releaseReset();
        @(negedge CLOCK_50);
        resetn   = 1'b1;
        n        = 0;
        dHsLow   = 0;
        sVsLow   = 0;
        sFeCount = 0;
        sLastFe  = -1;
    endtask

    // Drop reset between edges and confirm both outputs react before any clock.
    task automatic asyncReset(input int offset, input int holdCycles);
        @(negedge CLOCK_50);
        #(offset);
        resetn = 1'b0;
        #1;
        checkOutput("async_rst_d", dVec(), RESET_VEC);
        checkOutput("async_rst_s", sVec(), RESET_VEC);
        n = 0;
        repeat (holdCycles) begin
            @(negedge CLOCK_50);
            checkBoth();
        end
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("rst_d", dVec(), RESET_VEC);
        checkOutput("rst_s", sVec(), RESET_VEC);

        releaseReset();
        applyStimulus(1);
        checkOutput("tick_at_1", {31'b0, d_clk}, 32'd1);
        applyStimulus(1);
        checkOutput("x_at_2", 32'(d_x), 32'd1);
        applyStimulus(1276);
        checkOutput("x_at_1278", 32'(d_x), 32'd639);
        checkOutput("von_at_639", {31'b0, d_video_on}, 32'd1);
        applyStimulus(2);
        checkOutput("von_at_640", {31'b0, d_video_on}, 32'd0);
        applyStimulus(320);
        checkOutput("hs_low_line0", 32'(dHsLow), 32'd192);
        checkOutput("wrap_y", 32'(d_y), 32'd1);
        applyStimulus(800);
        checkOutput("x_400", 32'(d_x), 32'd400);
        checkOutput("fe_count_small", 32'(sFeCount), 32'd14);
        checkOutput("vs_low_small", 32'(sVsLow), 32'd336);

        asyncReset(3, 2);
        releaseReset();
        applyStimulus(2);
        checkOutput("resume_x", 32'(d_x), 32'd1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(int'($urandom_range(1, 3000)));
            asyncReset(int'($urandom_range(1, 8)), int'($urandom_range(1, 4)));
            releaseReset();
        end
        applyStimulus(400);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, the vertical equivalents in lines.
REQ-006 SHALL have port CLOCK_50, input, 1 bit: the single 50 MHz clock; all state rising-edge.
REQ-007 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port x, output, 12 bits: current horizontal pixel coordinate, equal to the horizontal counter.
REQ-009 SHALL have port y, output, 12 bits: current vertical line coordinate, equal to the vertical counter.
REQ-010 SHALL have port video_on, output, 1 bit: high when x < H_ACTIVE and y < V_ACTIVE.
REQ-011 SHALL have port vga_hs, output, 1 bit: horizontal sync, active-low.
REQ-012 SHALL have port vga_vs, output, 1 bit: vertical sync, active-low.
REQ-013 SHALL have port vga_clk, output, 1 bit: 25 MHz pixel clock, equal to the pix_tick register.
REQ-014 SHALL have port frame_end, output, 1 bit: single-cycle pulse at the last pixel of a frame.

Function
REQ-015 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL as the vertical equivalent (525).
REQ-016 SHALL hold a pix_tick register that toggles on every CLOCK_50 edge, dividing by 2.
REQ-017 SHALL advance the horizontal counter only on edges where pix_tick==1, so each pixel lasts exactly 2 CLOCK_50 cycles.
REQ-018 SHALL wrap the horizontal counter from H_TOTAL-1 to 0 and, on that same edge, increment the vertical counter.
REQ-019 SHALL wrap the vertical counter from V_TOTAL-1 to 0 when the horizontal counter also wraps; it never exceeds V_TOTAL-1.
REQ-020 SHALL drive vga_hs low iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-021 SHALL drive vga_vs low iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-022 SHALL decode x, y, video_on, vga_hs and vga_vs from counter registers only, with no input-to-output combinational path.
REQ-023 SHALL assert frame_end for exactly one CLOCK_50 cycle, when pix_tick==1, x==H_TOTAL-1 and y==V_TOTAL-1.
REQ-024 SHALL keep the upper bits of x and y zero (values < 1024); counter widths SHALL be sufficient for the parameters, zero-extended to 12 bits.
REQ-025 SHALL produce a frame period of exactly 2*H_TOTAL*V_TOTAL = 840000 CLOCK_50 cycles with default parameters.

Reset
REQ-026 SHALL, while resetn==0 and asynchronously on its assertion, force pix_tick=0, x=0, y=0.
REQ-027 SHALL therefore drive the following during reset: vga_clk=0, vga_hs=1, vga_vs=1, video_on=1, frame_end=0.
REQ-028 SHALL, after resetn rises, have pix_tick=1 at the first edge and x=1 at the second edge, so (0,0) is held for 2 cycles.
REQ-029 SHALL, on reset asserted mid-frame, return immediately to REQ-026 state and resume per REQ-028 with no partial-line carryover.

Verification
REQ-030 Release reset, count cycles: x reaches 1 at cycle 2, reaches 639 at cycle 1278, and video_on falls at the cycle where x becomes 640.
REQ-031 Run one line: vga_hs low for exactly 192 cycles, starting when x becomes 656; x wraps 799->0 with y incrementing 0->1 on the same edge.
REQ-032 Run two frames: frame_end pulses exactly once per frame, 840000 cycles apart; vga_vs low for exactly 2 lines (3200 cycles) at y=490..491.
REQ-033 Check y never exceeds 524, x never exceeds 799, and video_on==0 for all y>=480.
REQ-034 Assert resetn low at x=400,y=300 between clock edges: outputs go to x=0, y=0, vga_hs=1 without waiting for a clock edge; resume per REQ-028 after release.
REQ-035 Override parameters to H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1: frame_end period is 2*12*7 = 168 cycles and vga_hs is low at x=9..10.
